imem_responder: RTL and testbench
=================================

Name: imem_responder

Overview:
Instruction-memory responder for the npc core. It is the serving end of the fetch interface: it accepts a PC fetch request and returns the 32-bit instruction after a programmable latency through a valid/ready handshake. A word-wide write port lets the bench or a loader preload the program image. It replaces the C-side instruction supply and prepares the core for multi-cycle fetch.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words stored (power of two).
BASE_ADDR, 32'h80000000, byte address of word 0; the core reset PC maps here.
LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..15.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req_valid  input  1  fetch request valid
req_ready  output  1  responder can accept a request
req_addr  input  32  byte address (PC) of the fetch
resp_valid  output  1  instruction response valid
resp_ready  input  1  core accepts the response
resp_inst  output  32  fetched instruction word
resp_err  output  1  fetch fault (misaligned or out of range)
wr_en  input  1  preload write strobe
wr_addr  input  32  byte address of the preload word
wr_data  input  32  preload word
busy  output  1  request outstanding (state != IDLE)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, resp_valid=0, resp_inst=0, resp_err=0, busy=0, req_ready=0, latency counter=0. Memory contents are not cleared. On rst=1, req_ready=1 from the first rising edge onward.
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, capture req_addr, load counter=LATENCY-1, then go to WAIT, or to RESP directly if LATENCY=1.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: resp_valid=1 and resp_inst/resp_err held stable until resp_valid&resp_ready, then return to IDLE. A new request is accepted no earlier than the cycle after the handshake: one request outstanding, no overlap.
- Latency: with no backpressure, resp_valid rises exactly LATENCY cycles after the accept edge.
- Data capture: resp_inst/resp_err are registered on the edge that enters RESP. Word index = (addr-BASE_ADDR)>>2.
- Fault rules, evaluated on the captured address:
  - addr[1:0]!=0 gives resp_err=1, resp_inst=0.
  - addr<BASE_ADDR or addr>=BASE_ADDR+4*DEPTH_WORDS gives resp_err=1, resp_inst=0.
  - Subtraction is 32-bit unsigned; wrap below BASE counts as out of range.
- Write port: independent of the FSM and accepted in any state.
  - In range and aligned: mem[index] <= wr_data.
  - Misaligned or out of range: write ignored silently.
  - Write on the same edge as the RESP capture to the same word: response returns the OLD word (read-before-write). Writes earlier than that edge are visible.
- resp_ready held high with resp_valid low has no effect. req_valid held high while req_ready=0 is not captured.
- Reset asserted mid-WAIT or mid-RESP: the pending response is dropped and resp_valid falls immediately (async).

Optional Feature:
IMEM_EBREAK_FILL_EN
- Defined: an aligned out-of-range fetch returns resp_inst=32'h00100073 (ebreak) with resp_err=0, so a runaway PC halts the simulation cleanly. Misaligned fetches still fault.
- Not defined: out-of-range fetches fault as specified in Behaviour.

Test Plan:
- Preload mem[0]=32'h00500093, LATENCY=1; request 32'h80000000 with resp_ready=1 -> resp_valid one cycle after accept, resp_inst=32'h00500093, resp_err=0, req_ready low for exactly 1 cycle after accept.
- LATENCY=4; request 32'h80000004 with mem[1]=32'h00108113 and resp_ready=0 for 3 cycles -> resp_valid rises 4 cycles after accept and holds value stable; return to IDLE on the first cycle with resp_ready=1.
- Request 32'h80000002 -> resp_err=1, resp_inst=0. Request 32'h7FFFFFFC and 32'h80001000 (DEPTH 1024) -> resp_err=1. With IMEM_EBREAK_FILL_EN, the latter two return 32'h00100073, err=0.
- LATENCY=2; write 32'hDEADBEEF to the requested word on the RESP-capture edge -> response shows the old word; the next fetch of the same address returns 32'hDEADBEEF.
- Assert rst=0 during WAIT and during RESP -> resp_valid and busy go low asynchronously; after release, preloaded data is intact and a fresh fetch succeeds.
- Back-to-back fetches of 32'h80000000, 32'h80000004, 32'h80000008 with req_valid held high -> exactly three responses in order, no duplicate or dropped captures.

Source files
------------

// File: rtl/imem_responder_if.sv
`timescale 1ns/1ps
// Fetch request/response bundle between the core (master) and the instruction memory (slave).
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, resp_ready,
    input  req_ready, resp_valid, resp_inst, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready,
    output req_ready, resp_valid, resp_inst, resp_err
  );
endinterface

// File: rtl/imem_responder.sv
`timescale 1ns/1ps
// Instruction memory responder: one fetch outstanding; the response appears LATENCY cycles after the accept cycle and is held until resp_ready.
// Define IMEM_EBREAK_FILL_EN to answer aligned out-of-range fetches with ebreak instead of a fault.
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h80000000,
  parameter int          LATENCY     = 1
) (
  input  logic            clk,
  input  logic            rst,
  imem_responder_if.slave fetch,
  input  logic            wr_en,
  input  logic [31:0]     wr_addr,
  input  logic [31:0]     wr_data,
  output logic            busy
);
  localparam int          IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN   = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        up;
  logic        accept, capture;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] wr_off, rd_off, cap_addr, cap_inst;
  logic        wr_ok, rd_ok, cap_err;

  assign wr_off = wr_addr - BASE_ADDR;
  assign wr_ok  = wr_en && (wr_addr[1:0] == 2'b00) && (wr_addr >= BASE_ADDR) && (wr_off < SPAN);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_off[IDX_W+1:2]] <= wr_data;
    end
  end

  // With LATENCY=1 the capture happens on the accept edge, before addr_q holds the request.
  assign cap_addr = (state == IDLE) ? fetch.req_addr : addr_q;
  assign rd_off   = cap_addr - BASE_ADDR;
  assign rd_ok    = (cap_addr >= BASE_ADDR) && (rd_off < SPAN);

  always_comb begin
    cap_inst = 32'h0;
    cap_err  = 1'b1;
    if (cap_addr[1:0] != 2'b00) begin
      cap_inst = 32'h0;
      cap_err  = 1'b1;
    end else if (rd_ok) begin
      cap_inst = mem[rd_off[IDX_W+1:2]];
      cap_err  = 1'b0;
    end else begin
`ifdef IMEM_EBREAK_FILL_EN
      cap_inst = 32'h00100073;  // ebreak
      cap_err  = 1'b0;
`else
      cap_inst = 32'h0;
      cap_err  = 1'b1;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (fetch.req_valid && up) begin
          accept  = 1'b1;
          cnt_nxt = LAT_M1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
            capture   = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
          capture   = 1'b1;
        end
      end
      RESP: begin
        if (fetch.resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      up     <= 1'b0;
      addr_q <= 32'h0;
      inst_q <= 32'h0;
      err_q  <= 1'b0;
    end else begin
      up    <= 1'b1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q <= fetch.req_addr;
      end
      if (capture) begin
        inst_q <= cap_inst;
        err_q  <= cap_err;
      end
    end
  end

  assign fetch.req_ready  = up && (state == IDLE);
  assign fetch.resp_valid = (state == RESP);
  assign fetch.resp_inst  = inst_q;
  assign fetch.resp_err   = err_q;
  assign busy             = (state != IDLE);
endmodule

// File: tb/tb_imem_responder.sv
`timescale 1ns/1ps
// Three responders (LATENCY 1, 2, 4) checked against a due-time model every cycle, plus hand-computed directed checks.
module tb_imem_responder;
  localparam int          N      = 3;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h80000000;
  localparam logic [31:0] EBREAK = 32'h00100073;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid  [N];
  logic [31:0] req_addr   [N];
  logic        resp_ready [N];
  logic        wr_en      [N];
  logic [31:0] wr_addr    [N];
  logic [31:0] wr_data    [N];
  logic        dut_req_ready  [N];
  logic        dut_resp_valid [N];
  logic [31:0] dut_resp_inst  [N];
  logic        dut_resp_err   [N];
  logic        dut_busy       [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    imem_responder_if bus();
    assign bus.req_valid      = req_valid[g];
    assign bus.req_addr       = req_addr[g];
    assign bus.resp_ready     = resp_ready[g];
    assign dut_req_ready[g]   = bus.req_ready;
    assign dut_resp_valid[g]  = bus.resp_valid;
    assign dut_resp_inst[g]   = bus.resp_inst;
    assign dut_resp_err[g]    = bus.resp_err;
    imem_responder #(
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (BASE),
      .LATENCY    ((g == 0) ? 1 : ((g == 1) ? 2 : 4))
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .fetch  (bus),
      .wr_en  (wr_en[g]),
      .wr_addr(wr_addr[g]),
      .wr_data(wr_data[g]),
      .busy   (dut_busy[g])
    );
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h", name, k, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int k);
    total++;
    bad++;
    $display("FAIL %s dut%0d: no event within cycle budget", name, k);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] sh  [N][DEPTH];
  bit          shk [N][DEPTH];
  bit          m_started [N];
  bit          m_busy    [N];
  bit          m_valid   [N];
  bit          m_err     [N];
  bit          m_known   [N];
  logic [31:0] m_inst    [N];
  logic [31:0] m_addr    [N];
  longint      m_due     [N];
  longint      cyc = 0;

  function automatic bit in_range(input logic [31:0] a);
    longint ua = longint'({32'h0, a});
    longint ub = longint'({32'h0, BASE});
    return (ua >= ub) && (ua < ub + 4 * DEPTH);
  endfunction

  function automatic void lookup(input int k, input logic [31:0] a,
                                 output logic [31:0] inst, output bit err, output bit known);
    known = 1'b1;
    if (a % 4 != 0) begin
      inst = 32'h0;
      err  = 1'b1;
    end else if (!in_range(a)) begin
`ifdef IMEM_EBREAK_FILL_EN
      inst = EBREAK;
      err  = 1'b0;
`else
      inst = 32'h0;
      err  = 1'b1;
`endif
    end else begin
      inst  = sh[k][(a - BASE) / 4];
      known = shk[k][(a - BASE) / 4];
      err   = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_started[k] = 1'b0;
      m_busy[k]    = 1'b0;
      m_valid[k]   = 1'b0;
    end
  endfunction

  function automatic void model_step(input int k);
    bit rdy = m_started[k] && !m_busy[k];
    if (m_valid[k] && resp_ready[k]) begin
      m_valid[k] = 1'b0;
      m_busy[k]  = 1'b0;
    end else if (rdy && req_valid[k]) begin
      m_busy[k] = 1'b1;
      m_addr[k] = req_addr[k];
      m_due[k]  = cyc + lat_of(k) - 1;
    end
    if (m_busy[k] && !m_valid[k] && cyc == m_due[k]) begin
      m_valid[k] = 1'b1;
      lookup(k, m_addr[k], m_inst[k], m_err[k], m_known[k]);
    end
    if (wr_en[k] && wr_addr[k] % 4 == 0 && in_range(wr_addr[k])) begin
      sh[k][(wr_addr[k] - BASE) / 4]  = wr_data[k];
      shk[k][(wr_addr[k] - BASE) / 4] = 1'b1;
    end
    m_started[k] = 1'b1;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int k = 0; k < N; k++) model_step(k);
      end else begin
        model_reset();
      end
      cyc++;
      @(negedge clk);
      if (!rst) model_reset();
      for (int k = 0; k < N; k++) begin
        chk("req_ready", k, dut_req_ready[k], m_started[k] && !m_busy[k]);
        chk("busy", k, dut_busy[k], m_busy[k]);
        chk("resp_valid", k, dut_resp_valid[k], m_valid[k]);
        if (m_valid[k]) begin
          chk("resp_err", k, dut_resp_err[k], m_err[k]);
          if (m_known[k]) chk("resp_inst", k, dut_resp_inst[k], m_inst[k]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_all(input logic [31:0] a, input logic [31:0] d);
    for (int k = 0; k < N; k++) begin
      wr_en[k] = 1'b1; wr_addr[k] = a; wr_data[k] = d;
    end
    step();
    for (int k = 0; k < N; k++) wr_en[k] = 1'b0;
  endtask

  task automatic wait_ready(input int k);
    int n = 0;
    while (!dut_req_ready[k] && n < 50) begin step(); n++; end
    if (n >= 50) timeout("req_ready_wait", k);
  endtask

  // hold<0: resp_ready high from the start; otherwise low for hold cycles once valid.
  task automatic fetch(input int k, input logic [31:0] a, input int hold,
                       output logic [31:0] inst, output logic err, output int lat);
    int n;
    inst = 32'h0; err = 1'b0; lat = -1;
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    if (hold < 0) resp_ready[k] = 1'b1;
    wait_ready(k);
    step();
    req_valid[k] = 1'b0;
    n = 0;
    while (!dut_resp_valid[k] && n < 50) begin step(); n++; end
    if (n >= 50) begin
      timeout("resp_valid_wait", k);
      resp_ready[k] = 1'b0;
      return;
    end
    lat  = n + 1;
    inst = dut_resp_inst[k];
    err  = dut_resp_err[k];
    if (hold > 0) repeat (hold) step();
    resp_ready[k] = 1'b1;
    step();
    resp_ready[k] = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  logic [31:0] inst;
  logic        err;
  int          lat;
  logic [31:0] got_inst [3];

  initial begin
    for (int k = 0; k < N; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = 32'h0; resp_ready[k] = 1'b0;
      wr_en[k] = 1'b0; wr_addr[k] = 32'h0; wr_data[k] = 32'h0;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_resp_valid", k, dut_resp_valid[k], 1'b0);
      chk("rst_busy", k, dut_busy[k], 1'b0);
      chk("rst_req_ready", k, dut_req_ready[k], 1'b0);
      chk("rst_resp_inst", k, dut_resp_inst[k], 32'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("ready_before_edge", 0, dut_req_ready[0], 1'b0);
    step();
    chk("ready_after_edge", 0, dut_req_ready[0], 1'b1);

    wr_all(BASE,                32'h00500093);
    wr_all(BASE + 32'd4,        32'h00108113);
    wr_all(BASE + 32'd8,        32'h00208193);
    wr_all(BASE + 32'hFFC,      32'h0000006F);
    wr_all(BASE + 32'd1,        32'hFFFFFFFF);  // misaligned, dropped
    wr_all(BASE + 32'h1000,     32'hBAD0BAD0);  // out of range, would alias word 0

    fetch(0, BASE, -1, inst, err, lat);
    chk("lat1_latency", 0, lat, 1);
    chk("lat1_inst", 0, inst, 32'h00500093);
    chk("lat1_err", 0, err, 1'b0);
    chk("lat1_ready_back", 0, dut_req_ready[0], 1'b1);

    fetch(2, BASE + 32'd4, 3, inst, err, lat);
    chk("lat4_latency", 2, lat, 4);
    chk("lat4_inst", 2, inst, 32'h00108113);
    chk("lat4_idle_after_hs", 2, dut_busy[2], 1'b0);

    fetch(0, BASE + 32'hFFC, 0, inst, err, lat);
    chk("last_word_inst", 0, inst, 32'h0000006F);
    fetch(0, BASE + 32'd2, 0, inst, err, lat);
    chk("misaligned_err", 0, err, 1'b1);
    chk("misaligned_inst", 0, inst, 32'h0);
    fetch(1, 32'h7FFFFFFC, 0, inst, err, lat);
`ifdef IMEM_EBREAK_FILL_EN
    chk("below_base_err", 1, err, 1'b0);
    chk("below_base_inst", 1, inst, EBREAK);
`else
    chk("below_base_err", 1, err, 1'b1);
    chk("below_base_inst", 1, inst, 32'h0);
`endif
    fetch(2, 32'h80001000, 0, inst, err, lat);
`ifdef IMEM_EBREAK_FILL_EN
    chk("above_top_err", 2, err, 1'b0);
    chk("above_top_inst", 2, inst, EBREAK);
`else
    chk("above_top_err", 2, err, 1'b1);
    chk("above_top_inst", 2, inst, 32'h0);
`endif

    // Write lands on the same edge that captures the response.
    wait_ready(1);
    req_valid[1] = 1'b1; req_addr[1] = BASE + 32'd8;
    step();
    req_valid[1] = 1'b0;
    wr_en[1] = 1'b1; wr_addr[1] = BASE + 32'd8; wr_data[1] = 32'hDEADBEEF;
    step();
    wr_en[1] = 1'b0;
    chk("rbw_valid", 1, dut_resp_valid[1], 1'b1);
    chk("rbw_old_word", 1, dut_resp_inst[1], 32'h00208193);
    resp_ready[1] = 1'b1;
    step();
    resp_ready[1] = 1'b0;
    fetch(1, BASE + 32'd8, 0, inst, err, lat);
    chk("rbw_new_word", 1, inst, 32'hDEADBEEF);
    chk("lat2_latency", 1, lat, 2);

    // Reset during WAIT.
    wait_ready(2);
    req_valid[2] = 1'b1; req_addr[2] = BASE;
    step();
    req_valid[2] = 1'b0;
    step();
    chk("wait_busy_before", 2, dut_busy[2], 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("wait_rst_valid", 2, dut_resp_valid[2], 1'b0);
    chk("wait_rst_busy", 2, dut_busy[2], 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Reset during RESP.
    wait_ready(0);
    req_valid[0] = 1'b1; req_addr[0] = BASE + 32'd4;
    step();
    req_valid[0] = 1'b0;
    chk("resp_valid_before", 0, dut_resp_valid[0], 1'b1);
    pulse_reset();
    step();
    fetch(0, BASE, 0, inst, err, lat);
    chk("after_rst_inst", 0, inst, 32'h00500093);
    fetch(2, BASE + 32'd4, 0, inst, err, lat);
    chk("after_rst_inst", 2, inst, 32'h00108113);

    // Back-to-back fetches with req_valid held high.
    begin
      int got = 0;
      int ia  = 0;
      int extra = 0;
      bit acc, hs;
      req_valid[0] = 1'b1; req_addr[0] = BASE; resp_ready[0] = 1'b1;
      for (int c = 0; c < 40 && got < 3; c++) begin
        acc = req_valid[0] && dut_req_ready[0];
        hs  = dut_resp_valid[0] && resp_ready[0];
        if (hs) begin got_inst[got] = dut_resp_inst[0]; got++; end
        step();
        if (acc) begin
          ia++;
          if (ia < 3) req_addr[0] = BASE + 32'(4 * ia);
          else req_valid[0] = 1'b0;
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (dut_resp_valid[0]) extra++;
        step();
      end
      resp_ready[0] = 1'b0;
      chk("b2b_count", 0, got, 3);
      chk("b2b_extra", 0, extra, 0);
      if (got == 3) begin
        chk("b2b_inst0", 0, got_inst[0], 32'h00500093);
        chk("b2b_inst1", 0, got_inst[1], 32'h00108113);
        chk("b2b_inst2", 0, got_inst[2], 32'h00208193);
      end
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
